// File: rtl/different_width_fifo.sv
// Wide-in / narrow-out FIFO: stores IN_WIDTH words and pops OUT_WIDTH slices, LSB slice first.
// Define DWF_ERR_EN to add a sticky overrun/underrun flag on port err.
module different_width_fifo #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 4,
   parameter int DEPTH     = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [IN_WIDTH-1:0]  d,
   output logic [OUT_WIDTH-1:0] q,
   output logic                 full,
`ifdef DWF_ERR_EN
   output logic                 empty,
   output logic                 err
`else
   output logic                 empty
`endif
);

   localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
   localparam int SLICES = DEPTH * RATIO;
   localparam int WA     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW     = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int CW     = $clog2(SLICES + 1);

   logic [IN_WIDTH-1:0]  mem [DEPTH];
   logic [WA-1:0]        wr_ptr;
   logic [WA-1:0]        rd_word;
   logic [SW-1:0]        rd_slice;
   logic [CW-1:0]        count;
   logic                 push_ok;
   logic                 pop_ok;
   logic [IN_WIDTH-1:0]  rd_data;
   logic [OUT_WIDTH-1:0] rd_sel;
   logic [CW-1:0]        count_nxt;

   // Flags come straight from the registered count, so they only move on clk.
   assign empty   = (count == '0);
   assign full    = (count > CW'(SLICES - RATIO));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_word];

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (rd_slice == SW'(i)) rd_sel = rd_data[i*OUT_WIDTH +: OUT_WIDTH];
      end
   end

   always_comb begin
      count_nxt = count;
      if (push_ok) count_nxt = count_nxt + CW'(RATIO);
      if (pop_ok)  count_nxt = count_nxt - CW'(1);
   end

   // Storage is data-only and needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_word  <= '0;
         rd_slice <= '0;
         count    <= '0;
         q        <= '0;
      end else begin
         count <= count_nxt;
         if (push_ok) wr_ptr <= wr_ptr + WA'(1);
         if (pop_ok) begin
            q <= rd_sel;
            // The slice pointer is kept as word + slice index so RATIO need not be a power of 2.
            if (rd_slice == SW'(RATIO - 1)) begin
               rd_slice <= '0;
               rd_word  <= rd_word + WA'(1);
            end else begin
               rd_slice <= rd_slice + SW'(1);
            end
         end
      end
   end

`ifdef DWF_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if ((push && full) || (pop && empty)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_different_width_fifo.sv
// Directed bench for different_width_fifo with default parameters (8 -> 4, depth 64).
module tb_different_width_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   logic       pop;
   logic [7:0] d;
   logic [3:0] q;
   logic       full;
   logic       empty;
`ifdef DWF_ERR_EN
   logic       err;
`endif

   int total = 0;
   int bad   = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   different_width_fifo #(.IN_WIDTH(8), .OUT_WIDTH(4), .DEPTH(64)) dut (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .d     (d),
      .q     (q),
      .full  (full),
`ifdef DWF_ERR_EN
      .empty (empty),
      .err   (err)
`else
      .empty (empty)
`endif
   );

   task automatic do_cycle(input logic p, input logic r, input logic [7:0] v);
      push = p;
      pop  = r;
      d    = v;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; push = 1'b0; pop = 1'b0; d = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b want=0", full); end
      total++; if (q !== 4'h0)     begin bad++; $display("FAIL reset_q got=%h want=0", q); end
`ifdef DWF_ERR_EN
      total++; if (err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b want=0", err); end
`endif
   endtask

   task automatic test_single_push();
      do_cycle(1'b1, 1'b0, 8'h01);
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%b want=0", empty); end
      total++; if (full !== 1'b0)  begin bad++; $display("FAIL single_full got=%b want=0", full); end
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'h1) begin bad++; $display("FAIL single_pop1 got=%h want=1", q); end
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'h0) begin bad++; $display("FAIL single_pop2 got=%h want=0", q); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_drained got=%b want=1", empty); end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 64; i++) begin
         do_cycle(1'b1, 1'b0, 8'(i));
         total++;
         if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty n=%0d got=%b want=0", i, empty); end
         total++;
         if (full !== (i == 64)) begin bad++; $display("FAIL fill_full n=%0d got=%b want=%b", i, full, (i == 64)); end
      end
   endtask

   task automatic test_drain();
      for (int p = 1; p <= 128; p++) begin
         int k;
         logic [3:0] e;
         k = (p + 1) / 2;
         e = (p % 2 == 1) ? 4'(k % 16) : 4'(k / 16);
         do_cycle(1'b0, 1'b1, 8'h00);
         total++;
         if (q !== e) begin bad++; $display("FAIL drain_q pop=%0d got=%h want=%h", p, q, e); end
         if (p == 1) begin
            total++; if (full !== 1'b1) begin bad++; $display("FAIL drain_full1 got=%b want=1", full); end
         end
         if (p == 2) begin
            total++; if (full !== 1'b0) begin bad++; $display("FAIL drain_full2 got=%b want=0", full); end
         end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0)  begin bad++; $display("FAIL drain_full got=%b want=0", full); end
   endtask

   task automatic test_over_under();
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'h4)     begin bad++; $display("FAIL under_q got=%h want=4", q); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL under_empty got=%b want=1", empty); end
`ifdef DWF_ERR_EN
      total++; if (err !== 1'b1)   begin bad++; $display("FAIL under_err got=%b want=1", err); end
`endif
      for (int i = 1; i <= 64; i++) do_cycle(1'b1, 1'b0, 8'(i));
      do_cycle(1'b1, 1'b0, 8'hFF);
      total++; if (full !== 1'b1) begin bad++; $display("FAIL over_full got=%b want=1", full); end
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'h1) begin bad++; $display("FAIL over_first_lo got=%h want=1", q); end
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'h0) begin bad++; $display("FAIL over_first_hi got=%h want=0", q); end
      for (int p = 3; p <= 126; p++) do_cycle(1'b0, 1'b1, 8'h00);
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'h0) begin bad++; $display("FAIL over_last_lo got=%h want=0", q); end
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'h4) begin bad++; $display("FAIL over_last_hi got=%h want=4", q); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL over_empty got=%b want=1", empty); end
`ifdef DWF_ERR_EN
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
         w = 8'(i * 37 + 5);
         exp_q.push_back(w[3:0]);
         exp_q.push_back(w[7:4]);
         do_cycle(1'b1, 1'b0, w);
      end
      for (int i = 32; i < 72; i++) begin
         logic [3:0] e;
         w = 8'(i * 37 + 5);
         e = exp_q.pop_front();
         exp_q.push_back(w[3:0]);
         exp_q.push_back(w[7:4]);
         do_cycle(1'b1, 1'b1, w);
         total++;
         if (q !== e) begin bad++; $display("FAIL b2b_q cyc=%0d got=%h want=%h", i, q, e); end
      end
      total++; if (full !== 1'b0)  begin bad++; $display("FAIL b2b_full got=%b want=0", full); end
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", empty); end
      while (exp_q.size() > 0) begin
         logic [3:0] e;
         e = exp_q.pop_front();
         do_cycle(1'b0, 1'b1, 8'h00);
         total++;
         if (q !== e) begin bad++; $display("FAIL b2b_drain left=%0d got=%h want=%h", exp_q.size(), q, e); end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_final_empty got=%b want=1", empty); end
   endtask

   task automatic test_async_reset();
      do_cycle(1'b1, 1'b0, 8'h9C);
      do_cycle(1'b1, 1'b0, 8'h5A);
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'hC) begin bad++; $display("FAIL pre_reset_q got=%h want=c", q); end
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      total++; if (q !== 4'h0)     begin bad++; $display("FAIL arst_q got=%h want=0", q); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0)  begin bad++; $display("FAIL arst_full got=%b want=0", full); end
`ifdef DWF_ERR_EN
      total++; if (err !== 1'b0)   begin bad++; $display("FAIL arst_err got=%b want=0", err); end
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      do_cycle(1'b0, 1'b1, 8'h00);
      total++; if (q !== 4'h0)     begin bad++; $display("FAIL post_reset_q got=%h want=0", q); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL post_reset_empty got=%b want=1", empty); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill();
      test_drain();
      test_over_under();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/different_width_fifo.md
# different_width_fifo

Synchronous single-clock FIFO that accepts words of `IN_WIDTH` bits and delivers them as `OUT_WIDTH`-bit slices, least-significant slice first. It sits between a wide producer and a narrow consumer, for example byte-to-nibble serialization. Storage holds `DEPTH` input words. Full and empty flags are tracked at output-slice granularity.

## Interface
Parameters, in positional order:
- `IN_WIDTH`, default 8: push-side data width.
- `OUT_WIDTH`, default 4: pop-side data width. `IN_WIDTH` must be an integer multiple of `OUT_WIDTH`. `RATIO = IN_WIDTH/OUT_WIDTH`.
- `DEPTH`, default 64: capacity in input words. Must be a power of 2.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset. Asynchronous, active-low.
- `push`, input, 1: write request.
- `pop`, input, 1: read request.
- `d`, input, `IN_WIDTH`: write data.
- `q`, output, `OUT_WIDTH`: registered read data.
- `full`, output, 1: no room for another input word.
- `empty`, output, 1: no unread output slices.
- `err`, output, 1: present only with `DWF_ERR_EN` defined.

## Operation
- Storage: `DEPTH` × `IN_WIDTH` array.
- Write pointer counts in input words, `log2(DEPTH)` bits, wrapping.
- Read pointer counts in output slices, `log2(DEPTH*RATIO)` bits, wrapping.
- Fill count is kept in slices, range 0..`DEPTH*RATIO`.
- Accepted push (`push && !full`):
  - Writes `d` at the write pointer.
  - Increments the write pointer.
  - Adds `RATIO` to the count.
- Accepted pop (`pop && !empty`):
  - Loads into `q` the slice at the read pointer: word = `rdptr / RATIO`, bits `[(rdptr%RATIO)*OUT_WIDTH +: OUT_WIDTH]`.
  - Increments the read pointer and decrements the count by 1.
- Slice order within a word is LSB first. For `d = 8'h23` the pops yield 3, then 2.
- `empty` = (count == 0).
- `full` = (count > `DEPTH*RATIO - RATIO`), meaning less than one whole word of space remains.
- Flags are combinational from the registered count, so they are glitch-free relative to `clk`.
- Push while full: ignored, no state change.
- Pop while empty: ignored, `q` holds its value.
- Simultaneous push and pop:
  - Both are evaluated against the pre-edge flags and both take effect.
  - Count changes by `RATIO - 1`.
- A push into an empty FIFO plus a pop in the same cycle: the pop is ignored because `empty` was 1.
- `q` holds its last value between pops.

## Timing
- Reset values: `q` = 0, `empty` = 1, `full` = 0, pointers = 0, count = 0, `err` = 0.
- Reset is asynchronous on assertion. Release is sampled at the next `clk` edge.
- Reset asserted mid-operation discards all contents immediately.
- Push latency:
  - `empty` falls in the cycle after the first accepted push edge.
  - `full` rises in the cycle after the push edge that fills the FIFO.
- Pop latency: `q` is valid in the cycle after the pop edge (1-cycle read latency).
- `empty` rises in the cycle after the pop edge that removes the last slice.
- `full` falls in the cycle after the pop that frees at least one full word of space. This is `RATIO` pops from full.
- Throughput: one push and one pop per cycle.

## Configuration
- `DWF_ERR_EN` defined:
  - Adds output `err`, reset to 0.
  - `err` is set sticky on any push while `full` or pop while `empty`.
  - It is cleared only by reset.
- `DWF_ERR_EN` undefined:
  - Port `err` is absent.
  - Violations are silently ignored as described above.

## Test plan
- Reset with defaults (8,4,64), then release: `empty` = 1, `full` = 0, `q` = 0.
- One push of `d` = 1: `empty` = 0 the next cycle and `full` = 0.
- Push `d` = 1..64 on consecutive cycles:
  - `empty` = 0 and `full` = 0 through the 63rd push.
  - `full` = 1 the cycle after the 64th push.
- From full, pop 128 consecutive cycles:
  - After pop 2k−1, `q` = k%16. After pop 2k, `q` = k/16, for k = 1..64.
  - `empty` = 1 and `full` = 0 the cycle after the last pop.
- Overrun/underrun:
  - Push while full: contents unchanged.
  - Pop while empty: `q` holds.
  - With `DWF_ERR_EN`, `err` = 1 and stays 1 until reset.
- Simultaneous push/pop at steady half-full level:
  - Count rises by 1 per cycle.
  - Data order is preserved across pointer wrap-around.
- Assert `rst` mid-stream: outputs return to reset values immediately, without waiting for a clock edge.
